fifo_rd_stream: RTL and testbench

- Read-side consumer of the asynchronous FIFO, clocked entirely in the read domain.
- Drives the FIFO pop (rd_en) from its empty flag and captures the FIFO's registered read data into a 3-entry output buffer.
- Presents the data downstream as a valid/ready stream at full throughput with no combinational ready-to-rd_en path.
- Also provides a synchronous flush and a count of accepted beats.

---
 rtl/fifo_rd_stream.sv | 91 +++++++++
 tb/tb_fifo_rd_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side FIFO consumer: credit-based pop, 3-entry skid buffer, valid/ready stream out
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] beat_cnt
);

  logic [WIDTH-1:0] r_buf [3];
  logic [1:0]       r_wr_idx;
  logic [1:0]       r_rd_idx;
  logic [1:0]       r_occupancy;
  logic             r_inflight;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_credit;
  logic             w_capture;
  logic             w_pop;
  logic [1:0]       w_occ_next;

  function automatic logic [1:0] f_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // An in-flight word already owns a slot, so it counts against the credit.
  assign w_credit   = ({1'b0, r_occupancy} + {2'b00, r_inflight}) < 3'd3;
  assign fifo_rd_en = rd_rst_n & ~fifo_empty & ~flush & w_credit;
  assign w_capture  = r_inflight & ~flush;
  assign m_valid    = (r_occupancy != 2'd0);
  assign w_pop      = m_valid & m_ready;
  assign occupancy  = r_occupancy;
  assign beat_cnt   = r_beat_cnt;

  always_comb begin
    m_data = r_buf[0];
    for (int i = 1; i < 3; i++) begin
      if (r_rd_idx == 2'(i)) m_data = r_buf[i];
    end
  end

  always_comb begin
    w_occ_next = r_occupancy;
    if (w_capture && !w_pop) begin
      w_occ_next = r_occupancy + 2'd1;
    end else if (!w_capture && w_pop) begin
      w_occ_next = r_occupancy - 2'd1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < 3; i++) r_buf[i] <= '0;
      r_wr_idx    <= 2'd0;
      r_rd_idx    <= 2'd0;
      r_occupancy <= 2'd0;
      r_inflight  <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      r_inflight <= fifo_rd_en & ~fifo_empty;
      if (w_pop) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      if (flush) begin
        r_occupancy <= 2'd0;
        r_wr_idx    <= 2'd0;
        r_rd_idx    <= 2'd0;
      end else begin
        r_occupancy <= w_occ_next;
        if (w_capture) begin
          for (int i = 0; i < 3; i++) begin
            if (r_wr_idx == 2'(i)) r_buf[i] <= fifo_rd_data;
          end
          r_wr_idx <= f_inc(r_wr_idx);
        end
        if (w_pop) r_rd_idx <= f_inc(r_rd_idx);
      end
    end
  end

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(w_capture && (r_occupancy == 2'd3)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed bench for fifo_rd_stream with a behavioural FIFO read port
module tb_fifo_rd_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             rd_clk       = 1'b0;
  logic             rd_rst_n     = 1'b0;
  logic             fifo_empty   = 1'b1;
  logic [WIDTH-1:0] fifo_rd_data = '0;
  logic             fifo_rd_en;
  logic             flush        = 1'b0;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready      = 1'b0;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] beat_cnt;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .occupancy(occupancy), .beat_cnt(beat_cnt)
  );

  // FIFO read port: registered data, empty flag updated only at read-clock edges.
  logic [WIDTH-1:0] mem [256];
  int wp = 0;
  int rp = 0;
  int pops = 0;

  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rp           <= wp;
      fifo_empty   <= 1'b1;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rp % 256];
      rp           <= rp + 1;
      pops         <= pops + 1;
      fifo_empty   <= (rp + 1 == wp);
    end else begin
      fifo_empty <= (rp == wp);
    end
  end

  int checks = 0;
  int failures = 0;
  logic prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    mem[wp % 256] = d;
    wp++;
  endtask

  task automatic step(input logic rdy, input logic fl);
    @(negedge rd_clk);
    m_ready = rdy;
    flush   = fl;
    #1;
  endtask

  task automatic mon(input logic rdy, input logic [WIDTH-1:0] base, inout int got);
    step(rdy, 1'b0);
    if (prev_stall) chk("hold", m_data, prev_data);
    if (m_valid && rdy) begin
      chk("order", m_data, base + got);
      got++;
    end
    prev_stall = m_valid && !rdy;
    prev_data  = m_data;
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst_n = 1'b0;
    m_ready  = 1'b0;
    flush    = 1'b0;
    repeat (2) @(negedge rd_clk);
    rd_rst_n   = 1'b1;
    prev_stall = 1'b0;
  endtask

  typedef struct {
    int               npush;
    logic             rdy;
    logic             rd_en;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [1:0]       occ;
    logic [CNT_W-1:0] beat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int got;
    int p0;
    logic [WIDTH-1:0] nxt;

    tbl[0] = '{5, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'd0};
    tbl[1] = '{0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 4'd0};
    tbl[2] = '{0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 4'd0};
    tbl[3] = '{0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1, 4'd0};
    tbl[4] = '{0, 1'b1, 1'b1, 1'b1, 8'h12, 2'd1, 4'd1};
    tbl[5] = '{0, 1'b1, 1'b1, 1'b1, 8'h13, 2'd1, 4'd2};
    tbl[6] = '{0, 1'b1, 1'b0, 1'b1, 8'h14, 2'd1, 4'd3};
    tbl[7] = '{0, 1'b1, 1'b0, 1'b1, 8'h15, 2'd1, 4'd4};
    tbl[8] = '{0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'd5};

    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;

    // 5-word stream, m_ready held high
    nxt = 8'h11;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rdy, 1'b0);
      for (int k = 0; k < tbl[i].npush; k++) begin
        push(nxt);
        nxt = nxt + 8'h01;
      end
      chk($sformatf("tbl%0d_rd_en", i), fifo_rd_en, tbl[i].rd_en);
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
      chk($sformatf("tbl%0d_beat", i), beat_cnt, tbl[i].beat);
      if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), m_data, tbl[i].data);
    end

    // asynchronous reset with occupancy 2 and a word in flight
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    repeat (4) step(1'b0, 1'b0);
    chk("a_occ_before", occupancy, 2);
    #2;
    rd_rst_n = 1'b0;
    #1;
    chk("a_occ", occupancy, 0);
    chk("a_valid", m_valid, 0);
    chk("a_data", m_data, 0);
    chk("a_beat", beat_cnt, 0);
    chk("a_rd_en", fifo_rd_en, 0);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("a_post_occ", occupancy, 0);
    chk("a_post_valid", m_valid, 0);
    prev_stall = 1'b0;

    // backpressure: 8 words, 10 stalled cycles, then drain
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) push(8'h31 + 8'(i));
    p0  = pops;
    got = 0;
    repeat (10) mon(1'b0, 8'h31, got);
    chk("b_pops", pops - p0, 3);
    chk("b_occ", occupancy, 3);
    chk("b_rd_en", fifo_rd_en, 0);
    chk("b_head", m_data, 8'h31);
    for (int c = 0; c < 40 && got < 8; c++) mon(1'b1, 8'h31, got);
    chk("b_count", got, 8);
    step(1'b0, 1'b0);
    chk("b_beat", beat_cnt, 8);
    chk("b_empty_valid", m_valid, 0);

    // alternating m_ready with a word pushed every cycle
    prev_stall = 1'b0;
    got = 0;
    for (int c = 0; c < 60 && got < 12; c++) begin
      mon((c % 2) == 0, 8'h41, got);
      if (c < 12) push(8'h41 + 8'(c));
    end
    chk("c_count", got, 12);
    step(1'b0, 1'b0);
    chk("c_beat", beat_cnt, 4);

    // flush with occupancy 2 and 0x53 in flight; accepted beat at the flush edge counts
    do_reset();
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
    repeat (4) step(1'b0, 1'b0);
    chk("d_occ_before", occupancy, 2);
    flush   = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("d_rd_en_flush", fifo_rd_en, 0);
    step(1'b0, 1'b1);
    chk("d_occ", occupancy, 0);
    chk("d_valid", m_valid, 0);
    chk("d_rd_en_held", fifo_rd_en, 0);
    chk("d_beat_flush", beat_cnt, 1);
    step(1'b0, 1'b0);
    chk("d_rd_en_resume", fifo_rd_en, 1);
    prev_stall = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) mon(1'b1, 8'h54, got);
    chk("d_count", got, 2);
    step(1'b0, 1'b0);
    chk("d_beat", beat_cnt, 3);

    // 17 beats into a 4-bit counter
    do_reset();
    step(1'b0, 1'b0);
    for (int i = 0; i < 17; i++) push(8'h61 + 8'(i));
    got = 0;
    for (int c = 0; c < 60 && got < 17; c++) mon(1'b1, 8'h61, got);
    chk("e_count", got, 17);
    step(1'b0, 1'b0);
    chk("e_beat_wrap", beat_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
